// File: rtl/wave_pkg.sv
// Shared definitions for the triangle-wave capture path: sample and phase
// widths, the slope tracker state encoding, and the amplitude-to-phase decode
// used by both the decoder and any reference model.
package wave_pkg;

    localparam int SAMPLE_W = 12;
    localparam int PHASE_W  = 12;

    typedef enum logic [1:0] {
        ST_ACQ  = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } wave_state_e;

    // Maps a triangle amplitude back to phase. The sample LSB is dropped so the
    // rising half covers phases 0x000..0x7FF and the falling half mirrors it
    // into 0x800..0xFFF.
    function automatic logic [PHASE_W-1:0] tri_to_phase(
        input logic [SAMPLE_W-1:0] sample,
        input logic                falling
    );
        logic [SAMPLE_W-2:0] s;
        s = sample[SAMPLE_W-1:1];
        if (falling) begin
            tri_to_phase = {1'b1, ~s};
        end else begin
            tri_to_phase = {1'b0, s};
        end
    endfunction

endpackage

// File: rtl/tri_period_meter.sv
// Trough-to-trough period meter. Counts accepted samples while the decoder is
// tracking a slope, publishes the count on every trough after the first, and
// flags a timeout when no trough arrives before the count limit.
module tri_period_meter #(
    parameter int PERIOD_W   = 16,
    parameter int MAX_PERIOD = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid,
    input  logic                acquire,
    input  logic                trough_evt,
    output logic                timeout,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                locked
);

    // The sample that would push the count up to MAX_PERIOD is the timeout
    // sample, so the comparison is against the value one below the limit.
    localparam logic [PERIOD_W-1:0] CNT_LAST = PERIOD_W'(MAX_PERIOD - 1);
    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);

    logic [PERIOD_W-1:0] count_r,  count_s;
    logic                have_trough_r, have_trough_s;
    logic [PERIOD_W-1:0] period_r, period_s;
    logic                period_valid_r, period_valid_s;
    logic                locked_r, locked_s;
    logic                timeout_s;

    assign timeout_s    = valid & ~acquire & (count_r >= CNT_LAST);
    assign timeout      = timeout_s;
    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign locked       = locked_r;

    // Next-state for the counter; timeout wins over a trough on the same sample.
    always_comb begin
        count_s        = count_r;
        have_trough_s  = have_trough_r;
        period_s       = period_r;
        period_valid_s = 1'b0;
        locked_s       = locked_r;
        if (valid && !acquire) begin
            if (timeout_s) begin
                count_s       = {PERIOD_W{1'b0}};
                have_trough_s = 1'b0;
                locked_s      = 1'b0;
            end else if (trough_evt) begin
                if (have_trough_r) begin
                    period_s       = count_r;
                    period_valid_s = 1'b1;
                    locked_s       = 1'b1;
                end else begin
                    period_s       = period_r;
                end
                count_s       = CNT_ONE;
                have_trough_s = 1'b1;
            end else begin
                count_s = count_r + CNT_ONE;
            end
        end else begin
            count_s = count_r;
        end
    end

    // Counter and published period registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r        <= {PERIOD_W{1'b0}};
            have_trough_r  <= 1'b0;
            period_r       <= {PERIOD_W{1'b0}};
            period_valid_r <= 1'b0;
            locked_r       <= 1'b0;
        end else begin
            count_r        <= count_s;
            have_trough_r  <= have_trough_s;
            period_r       <= period_s;
            period_valid_r <= period_valid_s;
            locked_r       <= locked_s;
        end
    end

endmodule

// File: rtl/tri_phase_decoder.sv
// Triangle-to-phase decoder. Tracks slope direction with hysteresis around the
// running extreme, decodes each accepted sample into phase, emits peak/trough
// pulses on reversals and measures the trough-to-trough period.
module tri_phase_decoder
    import wave_pkg::*;
#(
    parameter int HYST       = 8,
    parameter int PERIOD_W   = 16,
    parameter int MAX_PERIOD = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic                out_valid,
    output logic [PHASE_W-1:0]  phase_out,
    output logic                dir,
    output logic                locked,
    output logic                peak_pulse,
    output logic                trough_pulse,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    // One extra bit so sample +/- HYST never wraps at either rail.
    localparam int             XW     = SAMPLE_W + 1;
    localparam logic [XW-1:0]  HYST_X = XW'(HYST);

    wave_state_e         state_r, state_s;
    logic [SAMPLE_W-1:0] ext_r, ext_s;
    logic                have_ref_r, have_ref_s;
    logic                out_valid_r, out_valid_s;
    logic [PHASE_W-1:0]  phase_r, phase_s;
    logic                dir_r, dir_s;
    logic                peak_r, peak_s;
    logic                trough_r, trough_s;

    logic [XW-1:0]       sample_x_s;
    logic [XW-1:0]       ext_x_s;
    logic                above_s;
    logic                below_s;
    logic                acquire_s;
    logic                trough_evt_s;
    logic                timeout_s;

    assign sample_x_s   = {1'b0, in_sample};
    assign ext_x_s      = {1'b0, ext_r};
    assign above_s      = sample_x_s > (ext_x_s + HYST_X);
    // Written as sample + HYST < ext so the subtraction never goes negative.
    assign below_s      = (sample_x_s + HYST_X) < ext_x_s;
    assign acquire_s    = (state_r == ST_ACQ);
    assign trough_evt_s = in_valid & (state_r == ST_FALL) & above_s;

    tri_period_meter #(
        .PERIOD_W   (PERIOD_W),
        .MAX_PERIOD (MAX_PERIOD)
    ) u_meter (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid        (in_valid),
        .acquire      (acquire_s),
        .trough_evt   (trough_evt_s),
        .timeout      (timeout_s),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked)
    );

    assign out_valid    = out_valid_r;
    assign phase_out    = phase_r;
    assign dir          = dir_r;
    assign peak_pulse   = peak_r;
    assign trough_pulse = trough_r;

    // Slope tracker next-state and decoded output stage.
    always_comb begin
        state_s     = state_r;
        ext_s       = ext_r;
        have_ref_s  = have_ref_r;
        out_valid_s = 1'b0;
        phase_s     = phase_r;
        dir_s       = dir_r;
        peak_s      = 1'b0;
        trough_s    = 1'b0;
        if (in_valid) begin
            case (state_r)
                ST_ACQ: begin
                    if (!have_ref_r) begin
                        ext_s      = in_sample;
                        have_ref_s = 1'b1;
                    end else if (above_s) begin
                        state_s     = ST_RISE;
                        ext_s       = in_sample;
                        out_valid_s = 1'b1;
                        phase_s     = tri_to_phase(in_sample, 1'b0);
                        dir_s       = 1'b0;
                    end else if (below_s) begin
                        state_s     = ST_FALL;
                        ext_s       = in_sample;
                        out_valid_s = 1'b1;
                        phase_s     = tri_to_phase(in_sample, 1'b1);
                        dir_s       = 1'b1;
                    end else begin
                        ext_s = ext_r;
                    end
                end
                ST_RISE: begin
                    if (timeout_s) begin
                        // Lost track: re-arm so the next sample is a fresh reference.
                        state_s    = ST_ACQ;
                        have_ref_s = 1'b0;
                    end else if (below_s) begin
                        state_s     = ST_FALL;
                        ext_s       = in_sample;
                        peak_s      = 1'b1;
                        out_valid_s = 1'b1;
                        phase_s     = tri_to_phase(in_sample, 1'b1);
                        dir_s       = 1'b1;
                    end else begin
                        if (sample_x_s > ext_x_s) begin
                            ext_s = in_sample;
                        end else begin
                            ext_s = ext_r;
                        end
                        out_valid_s = 1'b1;
                        phase_s     = tri_to_phase(in_sample, 1'b0);
                        dir_s       = 1'b0;
                    end
                end
                ST_FALL: begin
                    if (timeout_s) begin
                        state_s    = ST_ACQ;
                        have_ref_s = 1'b0;
                    end else if (above_s) begin
                        state_s     = ST_RISE;
                        ext_s       = in_sample;
                        trough_s    = 1'b1;
                        out_valid_s = 1'b1;
                        phase_s     = tri_to_phase(in_sample, 1'b0);
                        dir_s       = 1'b0;
                    end else begin
                        if (sample_x_s < ext_x_s) begin
                            ext_s = in_sample;
                        end else begin
                            ext_s = ext_r;
                        end
                        out_valid_s = 1'b1;
                        phase_s     = tri_to_phase(in_sample, 1'b1);
                        dir_s       = 1'b1;
                    end
                end
                default: begin
                    state_s    = ST_ACQ;
                    have_ref_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Tracker state, reference extreme and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_ACQ;
            ext_r       <= {SAMPLE_W{1'b0}};
            have_ref_r  <= 1'b0;
            out_valid_r <= 1'b0;
            phase_r     <= {PHASE_W{1'b0}};
            dir_r       <= 1'b0;
            peak_r      <= 1'b0;
            trough_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            ext_r       <= ext_s;
            have_ref_r  <= have_ref_s;
            out_valid_r <= out_valid_s;
            phase_r     <= phase_s;
            dir_r       <= dir_s;
            peak_r      <= peak_s;
            trough_r    <= trough_s;
        end
    end

endmodule

// File: tb/tb_tri_phase_decoder.sv
// Directed bench for tri_phase_decoder: generator-driven ramps with and
// without input gaps, single-sample decode cases, hysteresis edges, the
// no-trough timeout and an asynchronous mid-stream reset.
module tb_tri_phase_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_sample;
    logic        out_valid;
    logic [11:0] phase_out;
    logic        dir;
    logic        locked;
    logic        peak_pulse;
    logic        trough_pulse;
    logic [15:0] period;
    logic        period_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tri_phase_decoder #(
        .HYST       (8),
        .PERIOD_W   (16),
        .MAX_PERIOD (300)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_sample    (in_sample),
        .out_valid    (out_valid),
        .phase_out    (phase_out),
        .dir          (dir),
        .locked       (locked),
        .peak_pulse   (peak_pulse),
        .trough_pulse (trough_pulse),
        .period       (period),
        .period_valid (period_valid)
    );

    // Triangle generator: rising half carries phase in the upper 11 bits,
    // falling half carries its complement with the LSB set.
    function automatic logic [11:0] gen_sample(input logic [11:0] p);
        if (p[11]) gen_sample = {~p[10:0], 1'b1};
        else       gen_sample = {p[10:0], 1'b0};
    endfunction

    task automatic drive(input logic v, input logic [11:0] smp);
        @(negedge clk);
        in_valid  = v;
        in_sample = smp;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sample = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, dir, peak_pulse, trough_pulse, period_valid, locked, phase_out, period} !== 34'd0) begin
            n_errors++;
            $display("FAIL reset: got %h want 0",
                     {out_valid, dir, peak_pulse, trough_pulse, period_valid, locked, phase_out, period});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Three periods of phase stepping by 16; optional random idle cycles.
    task automatic test_ramp(input bit use_gaps);
        logic [11:0] p, e_ph;
        logic        e_ov, e_dir, e_pk, e_tr, e_pv, e_lk;
        logic [15:0] e_per;
        logic [33:0] obs, expv;
        int          g;
        apply_reset();
        for (int idx = 0; idx <= 780; idx++) begin
            if (use_gaps) begin
                g = int'($urandom_range(0, 2));
                for (int k = 0; k < g; k++) begin
                    drive(1'b0, 12'($urandom));
                    n_checks++;
                    if ({out_valid, peak_pulse, trough_pulse, period_valid} !== 4'b0000) begin
                        n_errors++;
                        $display("FAIL gap idx=%0d: got %b want 0000", idx,
                                 {out_valid, peak_pulse, trough_pulse, period_valid});
                    end
                end
            end
            p = 12'(idx * 16);
            drive(1'b1, gen_sample(p));
            e_ov  = (idx != 0);
            e_dir = (idx >= 129) && (((idx - 129) % 256) < 128);
            e_pk  = (idx >= 129) && (((idx - 129) % 256) == 0);
            e_tr  = (idx >= 257) && (((idx - 257) % 256) == 0);
            e_pv  = e_tr && (idx >= 513);
            e_lk  = (idx >= 513);
            e_per = (idx >= 513) ? 16'd256 : 16'd0;
            if (p == 12'h800)                 e_ph = 12'h7FF;
            else if (p == 12'h000 && idx != 0) e_ph = 12'hFFF;
            else                              e_ph = p;
            obs  = {out_valid, dir, peak_pulse, trough_pulse, period_valid, locked, phase_out, period};
            expv = {e_ov, e_dir, e_pk, e_tr, e_pv, e_lk, e_ph, e_per};
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL ramp gaps=%0d idx=%0d: got %h want %h", use_gaps, idx, obs, expv);
            end
        end
    endtask

    // Continues after the ungapped ramp: last trough was sample 769.
    task automatic test_timeout();
        int idx;
        for (int k = 1; k <= 300; k++) begin
            idx = 780 + k;
            drive(1'b1, 12'h300);
            if (idx <= 1059) begin
                n_checks++;
                if ({out_valid, dir, locked, phase_out, period} !== {1'b1, 1'b0, 1'b1, 12'h180, 16'd256}) begin
                    n_errors++;
                    $display("FAIL hold idx=%0d: got %h want %h", idx,
                             {out_valid, dir, locked, phase_out, period}, {1'b1, 1'b0, 1'b1, 12'h180, 16'd256});
                end
            end else if (idx >= 1074) begin
                n_checks++;
                if ({out_valid, locked, period} !== {1'b0, 1'b0, 16'd256}) begin
                    n_errors++;
                    $display("FAIL timeout idx=%0d: got %h want %h", idx,
                             {out_valid, locked, period}, {1'b0, 1'b0, 16'd256});
                end
            end
        end
        drive(1'b1, 12'h300);
        drive(1'b1, 12'h310);
        n_checks++;
        if ({out_valid, dir, locked, phase_out} !== {1'b1, 1'b0, 1'b0, 12'h188}) begin
            n_errors++;
            $display("FAIL restart: got %h want %h", {out_valid, dir, locked, phase_out},
                     {1'b1, 1'b0, 1'b0, 12'h188});
        end
    endtask

    task automatic test_decode();
        logic [11:0] smp [0:8];
        logic [5:0]  ef  [0:8];
        logic [11:0] ep  [0:8];
        smp = '{12'h000, 12'h040, 12'h0A0, 12'hFFE, 12'hF5F, 12'hF5F, 12'h000, 12'h008, 12'h009};
        ef  = '{6'b000000, 6'b100000, 6'b100000, 6'b100000, 6'b111000,
                6'b110000, 6'b110000, 6'b110000, 6'b100100};
        ep  = '{12'h000, 12'h020, 12'h050, 12'h7FF, 12'h850, 12'h850, 12'hFFF, 12'hFFB, 12'h004};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, smp[i]);
            n_checks++;
            if ({out_valid, dir, peak_pulse, trough_pulse, period_valid, locked, phase_out} !== {ef[i], ep[i]}) begin
                n_errors++;
                $display("FAIL decode step=%0d in=%h: got %h want %h", i, smp[i],
                         {out_valid, dir, peak_pulse, trough_pulse, period_valid, locked, phase_out}, {ef[i], ep[i]});
            end
        end
    endtask

    task automatic test_hysteresis();
        apply_reset();
        for (int v = 'h400; v <= 'h800; v += 'h10) drive(1'b1, 12'(v));
        n_checks++;
        if ({out_valid, dir, phase_out} !== {1'b1, 1'b0, 12'h400}) begin
            n_errors++;
            $display("FAIL hyst top: got %h want %h", {out_valid, dir, phase_out}, {1'b1, 1'b0, 12'h400});
        end
        drive(1'b1, 12'h7FA);
        n_checks++;
        if ({out_valid, dir, peak_pulse, trough_pulse, phase_out} !== {4'b1000, 12'h3FD}) begin
            n_errors++;
            $display("FAIL hyst drop6: got %h want %h", {out_valid, dir, peak_pulse, trough_pulse, phase_out},
                     {4'b1000, 12'h3FD});
        end
        drive(1'b1, 12'h7F8);
        n_checks++;
        if ({out_valid, dir, peak_pulse, trough_pulse, phase_out} !== {4'b1000, 12'h3FC}) begin
            n_errors++;
            $display("FAIL hyst drop8: got %h want %h", {out_valid, dir, peak_pulse, trough_pulse, phase_out},
                     {4'b1000, 12'h3FC});
        end
        drive(1'b1, 12'h7F7);
        n_checks++;
        if ({out_valid, dir, peak_pulse, trough_pulse, phase_out} !== {4'b1110, 12'hC04}) begin
            n_errors++;
            $display("FAIL hyst drop9: got %h want %h", {out_valid, dir, peak_pulse, trough_pulse, phase_out},
                     {4'b1110, 12'hC04});
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(1'b1, 12'h000);
        drive(1'b1, 12'h040);
        drive(1'b1, 12'h080);
        n_checks++;
        if ({out_valid, dir, phase_out} !== {1'b1, 1'b0, 12'h040}) begin
            n_errors++;
            $display("FAIL pre-reset ramp: got %h want %h", {out_valid, dir, phase_out}, {1'b1, 1'b0, 12'h040});
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, dir, peak_pulse, trough_pulse, period_valid, locked, phase_out, period} !== 34'd0) begin
            n_errors++;
            $display("FAIL async clear: got %h want 0",
                     {out_valid, dir, peak_pulse, trough_pulse, period_valid, locked, phase_out, period});
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive(1'b1, 12'h0C0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL post-reset first: got %b want 0", out_valid);
        end
        drive(1'b1, 12'h100);
        n_checks++;
        if ({out_valid, dir, phase_out} !== {1'b1, 1'b0, 12'h080}) begin
            n_errors++;
            $display("FAIL post-reset second: got %h want %h", {out_valid, dir, phase_out}, {1'b1, 1'b0, 12'h080});
        end
    endtask

    initial begin
        test_reset();
        test_ramp(1'b0);
        test_timeout();
        test_ramp(1'b1);
        test_decode();
        test_hysteresis();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
